// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the ripple/lookahead adder.
// The group width is fixed; wider adders are built from whole groups.
package adder_pkg;

    localparam int CLA_GROUP = 4;

    function automatic bit width_ok(input int width);
        return (width > 0) && (width % CLA_GROUP == 0);
    endfunction

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead group: flat carries from cin, no internal ripple.
// Group P/G are exported for a future second lookahead level.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       P,
    output logic       G
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // every carry is expanded back to cin so the group adds one level of logic
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

    assign P = &p;
    assign G = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/ripple_cla_adder.sv
// Adder of WIDTH/4 lookahead groups with rippled group carries,
// plus a registered copy of sum, carry and signed overflow.
module ripple_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovf_q
);

    localparam int NGRP = WIDTH / CLA_GROUP;

    if (!width_ok(WIDTH) || GROUP != CLA_GROUP) begin : g_bad_cfg
        $error("ripple_cla_adder: WIDTH must be a positive multiple of 4");
    end

    logic [NGRP:0]   gc;
    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_g;
    logic            c_msb;
    logic            ovf;
    logic            unused_pg;

    assign gc[0] = Cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla4_group u_grp (
            .a   (A[k*CLA_GROUP +: CLA_GROUP]),
            .b   (B[k*CLA_GROUP +: CLA_GROUP]),
            .cin (gc[k]),
            .s   (Sum[k*CLA_GROUP +: CLA_GROUP]),
            .cout(gc[k+1]),
            .P   (grp_p[k]),
            .G   (grp_g[k])
        );
    end

    assign Cout = gc[NGRP];

    // carry into the MSB recovered from its sum bit: s = a ^ b ^ c
    assign c_msb = A[WIDTH-1] ^ B[WIDTH-1] ^ Sum[WIDTH-1];
    assign ovf   = c_msb ^ Cout;

    assign unused_pg = ^{grp_p, grp_g};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum_q  <= '0;
            Cout_q <= 1'b0;
            Ovf_q  <= 1'b0;
        end else begin
            Sum_q  <= Sum;
            Cout_q <= Cout;
            Ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_ripple_cla_adder.sv
// Directed, exhaustive 4-bit and random 16-bit checks of ripple_cla_adder.
// Inputs change on falling edges; outputs are sampled 1ns after edges.
module tb_ripple_cla_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        c4 = 1'b0;
    logic [3:0]  s4, s4_q;
    logic        co4, co4_q, ov4_q;
    logic [15:0] a16 = '0, b16 = '0;
    logic        c16 = 1'b0;
    logic [15:0] s16, s16_q;
    logic        co16, co16_q, ov16_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ripple_cla_adder #(.WIDTH(4), .GROUP(4)) u_dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4),
        .Sum(s4), .Cout(co4), .Sum_q(s4_q), .Cout_q(co4_q), .Ovf_q(ov4_q)
    );

    ripple_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(c16),
        .Sum(s16), .Cout(co16), .Sum_q(s16_q), .Cout_q(co16_q), .Ovf_q(ov16_q)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive at negedge, check comb, then check registers after the next rise
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [3:0] es, input logic ec,
                        input logic eo);
        @(negedge clk);
        a4 = a; b4 = b; c4 = c;
        #1;
        check({tag, ".sum"}, 32'(s4), 32'(es));
        check({tag, ".cout"}, 32'(co4), 32'(ec));
        @(posedge clk);
        #1;
        check({tag, ".sum_q"}, 32'(s4_q), 32'(es));
        check({tag, ".cout_q"}, 32'(co4_q), 32'(ec));
        check({tag, ".ovf_q"}, 32'(ov4_q), 32'(eo));
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       c;
        logic [3:0] s;
        logic       co, ov;
    } vec_t;

    vec_t dir[8] = '{
        '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0},
        '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0},
        '{4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0},
        '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0},
        '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0},
        '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1},
        '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0},
        '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1}
    };

    initial begin
        // power-on reset
        @(negedge clk);
        #1;
        check("rst.sum_q", 32'(s4_q), 32'h0);
        check("rst.cout_q", 32'(co4_q), 32'h0);
        check("rst.ovf_q", 32'(ov4_q), 32'h0);
        check("rst.sum16_q", 32'(s16_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (dir[i])
            run4($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].c,
                 dir[i].s, dir[i].co, dir[i].ov);

        // asynchronous reset between edges
        run4("pre_rst", 4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.sum_q", 32'(s4_q), 32'h0);
        check("arst.cout_q", 32'(co4_q), 32'h0);
        check("arst.ovf_q", 32'(ov4_q), 32'h0);
        check("arst.sum", 32'(s4), 32'h6);
        @(posedge clk);
        #1;
        check("hold.sum_q", 32'(s4_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.sum_q", 32'(s4_q), 32'h0);
        @(posedge clk);
        #1;
        check("reload.sum_q", 32'(s4_q), 32'h6);

        // exhaustive 4-bit against an arithmetic reference
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a, b, s;
            logic       c, co, ov;
            logic [4:0] r;
            a  = 4'(i >> 5);
            b  = 4'(i >> 1);
            c  = i[0];
            r  = {1'b0, a} + {1'b0, b} + 5'(c);
            s  = r[3:0];
            co = r[4];
            ov = (a[3] == b[3]) && (s[3] != a[3]);
            run4("exh", a, b, c, s, co, ov);
        end

        // random 16-bit
        for (int i = 0; i < 10000; i++) begin
            logic [16:0] r;
            logic        ov;
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            if (i == 0) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
            end
            if (i == 1) begin
                a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0;
            end
            r  = {1'b0, a16} + {1'b0, b16} + 17'(c16);
            ov = (a16[15] == b16[15]) && (r[15] != a16[15]);
            #1;
            check("r16.sum", 32'(s16), 32'(r[15:0]));
            check("r16.cout", 32'(co16), 32'(r[16]));
            @(posedge clk);
            #1;
            check("r16.sum_q", 32'(s16_q), 32'(r[15:0]));
            check("r16.cout_q", 32'(co16_q), 32'(r[16]));
            check("r16.ovf_q", 32'(ov16_q), 32'(ov));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ripple_cla_adder.md
# ripple_cla_adder

Parameterised binary adder built from 4-bit carry-lookahead groups whose group carries ripple from one group to the next. It is a datapath leaf. It provides a combinational sum/carry result for same-cycle use and a registered copy of that result for pipelined consumers. The default configuration is a 4-bit adder with carry-in and carry-out.

## Interface
Parameters:
- WIDTH, 4, operand and sum width in bits; must be a positive multiple of GROUP.
- GROUP, 4, bits per carry-lookahead group; fixed at 4 in this revision.

Ports:
- clk  input  1  single clock; rising edge samples the registered outputs.
- rst  input  1  reset, asynchronous and active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- Sum  output  WIDTH  combinational (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  combinational carry out of bit WIDTH-1.
- Sum_q  output  WIDTH  registered Sum.
- Cout_q  output  1  registered Cout.
- Ovf_q  output  1  registered signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- Per bit i: generate g[i] = A[i] & B[i]; propagate p[i] = A[i] ^ B[i].
- Per group k (bits 4k..4k+3), with c0 = the group's carry-in:
  - Carries within the group are flat lookahead, with no ripple inside the group:
    - c1 = g0 | p0·c0
    - c2 = g1 | p1·g0 | p1·p0·c0
    - c3 likewise, expanded to c0
    - group carry-out c4 likewise, expanded to c0
  - Sum bit = p[i] ^ c[i].
- Group 0 carry-in = Cin. Group k carry-in = group k-1 carry-out (ripple between groups).
- Cout = carry-out of the last group. {Cout, Sum} equals the exact (WIDTH+1)-bit value A + B + Cin.
- All operands are unsigned for Sum and Cout. Ovf_q interprets A and B as two's complement.
- Wrap-around: an all-ones operand plus 1 gives Sum = 0 and Cout = 1.
- The maximum result, all-ones + all-ones + 1, gives Sum = all-ones and Cout = 1.
- No X-propagation masking. Sum and Cout are pure functions of A, B and Cin.

## Timing
- Sum and Cout are combinational: zero-cycle latency, valid within the same cycle inputs settle. They do not depend on clk or rst.
- Sum_q, Cout_q and Ovf_q take 1-cycle latency. They capture the combinational result on each rising clk edge. There is no enable, so they load every cycle.
- Reset:
  - rst high immediately (asynchronously) forces Sum_q = 0, Cout_q = 0, Ovf_q = 0.
  - Registered outputs hold 0 while rst is high.
  - The first capture happens at the first rising edge after rst deasserts.
- Reset asserted mid-operation discards the pending capture. Combinational outputs are unaffected by reset.
- Critical path: one group lookahead, then WIDTH/GROUP − 1 group ripples, then the sum XOR.

## Structure
- Shared package adder_pkg holds:
  - the constant CLA_GROUP = 4;
  - a function or localparam check that WIDTH % CLA_GROUP == 0, elaboration error otherwise.
- One sub-module, cla4_group:
  - inputs: a[3:0], b[3:0], cin;
  - outputs: s[3:0], cout, plus group propagate P and group generate G for future two-level lookahead.
- Top level:
  - instantiates WIDTH/4 copies of cla4_group in a generate loop with chained carries;
  - computes overflow from the MSB carry-in/carry-out;
  - contains the single always block for the output registers with async reset.

## Test plan
- A=0000, B=0000, Cin=0 -> Sum=0000, Cout=0; after a clock, Sum_q=0000, Cout_q=0.
- A=0001, B=0001, Cin=0 -> Sum=0010, Cout=0. A=0011, B=0011, Cin=0 -> Sum=0110, Cout=0.
- A=1111, B=0001, Cin=0 -> Sum=0000, Cout=1 (wrap). A=1010, B=0101, Cin=1 -> Sum=0000, Cout=1.
- Overflow: A=0111, B=0001, Cin=0 -> Sum=1000, Cout=0, Ovf_q=1 after one edge. A=1111, B=1111, Cin=1 -> Sum=1111, Cout=1, Ovf_q=0.
- Reset: load Sum_q=0110, then assert rst between clock edges -> Sum_q/Cout_q/Ovf_q go to 0 immediately while Sum stays 0110. Deassert rst -> registered outputs reload on the next rising edge.
- Exhaustive: all 512 combinations of A, B and Cin at WIDTH=4, plus 10k random vectors at WIDTH=16. Each must match the reference model {Cout, Sum} = A + B + Cin, with registered outputs matching one cycle later.
